// File: rtl/icb_sram_slv_if.sv
// ICB command/response bundle between a bus master and the SRAM slave.
// Handshake rule for both channels: a beat transfers on a rising clk edge
// where valid and ready are both 1; the sender holds valid and every payload
// field stable until that edge, and ready may never be a function of the
// payload of the same channel.
interface icb_sram_slv_if;
   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic [31:0] icb_cmd_addr;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready;
   logic        icb_rsp_err;
   logic [31:0] icb_rsp_rdata;

   modport master (
      output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
      output icb_rsp_ready,
      input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
   );

   modport slave (
      input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
      input  icb_rsp_ready,
      output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
   );
endinterface

// File: rtl/icb_sram_slv.sv
// ICB target in front of a single-port synchronous SRAM.
// A command is decoded and strobed to the SRAM in its accept cycle; stage S1
// holds the command class for the following cycle, when SRAM read data is
// available. S1 either feeds the response port directly (bypass) or lands in
// a small in-order response FIFO. Commands are only accepted while the FIFO
// plus S1 can absorb one more response, so responses are never dropped.
// Optional feature macro: ICB_SLV_MISALIGN_ERR_EN -- when defined, commands
// with addr[1:0] != 0 are answered with rsp_err=1 and never reach the SRAM.
module icb_sram_slv #(
   parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
   parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
   parameter int          AW        = 14,
   parameter int          RSP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   icb_sram_slv_if.slave icb,
   output logic          sram_cs,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   output logic [3:0]    sram_wem,
   input  logic [31:0]   sram_rdata
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [31:0]   offset;
   logic          hit;
   logic          err_ext;
   logic          accept;
   logic [CW-1:0] occupancy;

   logic          s1_valid;
   logic          s1_read;
   logic          s1_err;
   logic          s1_rsp_err;
   logic [31:0]   s1_rsp_rdata;

   logic [31:0]   fifo_rdata [RSP_DEPTH];
   logic          fifo_err   [RSP_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   // Address decode: subtracting the base makes addresses below it wrap to a
   // huge offset, so a single unsigned compare covers both window edges.
   assign offset = icb.icb_cmd_addr - ADDR_BASE;
   assign hit    = (offset < ADDR_SIZE);

`ifdef ICB_SLV_MISALIGN_ERR_EN
   assign err_ext = |icb.icb_cmd_addr[1:0];
`else
   assign err_ext = 1'b0;
`endif

   // Credit check ignores a pop in the same cycle; costs a bubble only when full.
   assign occupancy         = fifo_cnt + CW'(s1_valid);
   assign icb.icb_cmd_ready = (occupancy < CW'(RSP_DEPTH));
   assign accept            = icb.icb_cmd_valid & icb.icb_cmd_ready;

   // SRAM strobes exist only in the accept cycle of a decodable command.
   assign sram_cs    = accept & hit & ~err_ext;
   assign sram_we    = sram_cs & ~icb.icb_cmd_read;
   assign sram_addr  = offset[AW+1:2];
   assign sram_wdata = icb.icb_cmd_wdata;
   assign sram_wem   = icb.icb_cmd_wmask;

   // Stage S1: remembers what was accepted last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_read  <= 1'b0;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_read  <= icb.icb_cmd_read;
         s1_err   <= ~hit | err_ext;
      end
   end

   // S1 response: read data only for good reads, zero for writes and errors.
   assign s1_rsp_err   = s1_valid & s1_err;
   assign s1_rsp_rdata = (s1_valid & s1_read & ~s1_err) ? sram_rdata : 32'h0;

   assign fifo_empty = (fifo_cnt == '0);
   assign pop        = ~fifo_empty & icb.icb_rsp_ready;
   assign push       = s1_valid & ~(fifo_empty & icb.icb_rsp_ready);

   // Response FIFO storage, circular pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_rdata[i] <= 32'h0;
            fifo_err[i]   <= 1'b0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_rdata[wr_ptr] <= s1_rsp_rdata;
            fifo_err[wr_ptr]   <= s1_rsp_err;
            if (wr_ptr == PW'(RSP_DEPTH - 1)) wr_ptr <= '0;
            else                              wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            if (rd_ptr == PW'(RSP_DEPTH - 1)) rd_ptr <= '0;
            else                              rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Response mux: the FIFO head is always older than S1, so it goes first.
   always_comb begin
      icb.icb_rsp_valid = ~fifo_empty | s1_valid;
      icb.icb_rsp_err   = s1_rsp_err;
      icb.icb_rsp_rdata = s1_rsp_rdata;
      if (!fifo_empty) begin
         icb.icb_rsp_err   = fifo_err[rd_ptr];
         icb.icb_rsp_rdata = fifo_rdata[rd_ptr];
      end
   end

endmodule

// File: tb/tb_icb_sram_slv.sv
// Self-checking bench for icb_sram_slv: a behavioural SRAM, a word-array
// reference model of the address window and an in-order expected-response
// queue drained by a response monitor.
module tb_icb_sram_slv;

   localparam logic [31:0] BASE = 32'h2000_0000;
   localparam logic [31:0] SIZE = 32'h0001_0000;
   localparam int          AW   = 14;
   localparam int          W    = 33;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sram_cs;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [3:0]    sram_wem;
   logic [31:0]   sram_rdata;

   logic [1:0]    rdy_mode;   // 0 = hold low, 1 = hold high, 2 = random
   logic          rand_bit = 1'b1;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;

   logic [31:0]   sram_mem [0:(1<<AW)-1];
   logic [31:0]   ref_mem  [0:(1<<AW)-1];
   logic [W-1:0]  exp_q[$];

   icb_sram_slv_if icb ();

   icb_sram_slv #(
      .ADDR_BASE(BASE),
      .ADDR_SIZE(SIZE),
      .AW(AW),
      .RSP_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .icb(icb),
      .sram_cs(sram_cs),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_wem(sram_wem),
      .sram_rdata(sram_rdata)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Response-ready source
   always begin
      @(posedge clk);
      #1;
      rand_bit = ($urandom_range(0, 3) != 0);
   end
   assign icb.icb_rsp_ready = (rdy_mode == 2'd2) ? rand_bit : rdy_mode[0];

   // Behavioural single-port SRAM: read data one cycle after cs & ~we
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_wem[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   // Reference model: decode window, optional alignment rule, byte-masked words
   task automatic model_cmd(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                            input logic [3:0] wm, output logic ok, output logic [W-1:0] exp);
      logic [31:0] off;
      logic        mis;
      int          idx;
      off = a - BASE;
      mis = 1'b0;
`ifdef ICB_SLV_MISALIGN_ERR_EN
      mis = (a[1:0] != 2'b00);
`endif
      ok  = (off < SIZE) && !mis;
      idx = int'(off / 4);
      if (!ok) begin
         exp = {1'b1, 32'h0};
      end else if (rd) begin
         exp = {1'b0, ref_mem[idx]};
      end else begin
         for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
         exp = {1'b0, 32'h0};
      end
   endtask

   // Driver: present one command, wait (bounded) for acceptance
   task automatic send(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
      int           n;
      logic         ok;
      logic [W-1:0] exp;
      logic [31:0]  off;
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_addr  = a;
      icb.icb_cmd_read  = rd;
      icb.icb_cmd_wdata = wd;
      icb.icb_cmd_wmask = wm;
      n = 0;
      @(negedge clk);
      while (!icb.icb_cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (icb.icb_cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL cmd_accept_timeout addr=%h ready=%b required=1", a, icb.icb_cmd_ready);
      end else begin
         model_cmd(a, rd, wd, wm, ok, exp);
         exp_q.push_back(exp);
         off = a - BASE;
         checks++;
         if (sram_cs !== ok) begin
            failures++;
            $display("FAIL sram_cs addr=%h got=%b required=%b", a, sram_cs, ok);
         end
         if (ok) begin
            checks++;
            if (sram_addr !== off[AW+1:2] || sram_we !== ~rd) begin
               failures++;
               $display("FAIL sram_addr_we addr=%h got=%h/%b required=%h/%b",
                        a, sram_addr, sram_we, off[AW+1:2], ~rd);
            end
            if (!rd) begin
               checks++;
               if (sram_wdata !== wd || sram_wem !== wm) begin
                  failures++;
                  $display("FAIL sram_wdata got=%h/%h required=%h/%h", sram_wdata, sram_wem, wd, wm);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      icb.icb_cmd_valid = 1'b0;
   endtask

   // Let outstanding responses drain (bounded); final emptiness is checked at the end
   task automatic drain();
      int n;
      rdy_mode = 2'd1;
      n = 0;
      while ((exp_q.size() != 0 || icb.icb_rsp_valid) && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: ordering, data, and stability while stalled
   task automatic monitor();
      logic         held = 1'b0;
      logic [W-1:0] held_v = '0;
      logic [W-1:0] obs;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         obs = {icb.icb_rsp_err, icb.icb_rsp_rdata};
         if (!rst_n) begin
            held = 1'b0;
         end else if (icb.icb_rsp_valid) begin
            if (held) begin
               checks++;
               if (obs !== held_v) begin
                  failures++;
                  $display("FAIL rsp_stable got=%h required=%h", obs, held_v);
               end
            end
            if (icb.icb_rsp_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL rsp_unexpected got=%h required=no response", obs);
               end else begin
                  exp = exp_q.pop_front();
                  if (obs !== exp) begin
                     failures++;
                     $display("FAIL rsp_data got=%h required=%h", obs, exp);
                  end
               end
               held = 1'b0;
            end else begin
               held   = 1'b1;
               held_v = obs;
            end
         end else begin
            if (held) begin
               checks++;
               failures++;
               $display("FAIL rsp_valid_dropped got=0 required=1");
            end
            held = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (icb.icb_rsp_valid !== 1'b0 || icb.icb_rsp_err !== 1'b0 || icb.icb_rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rsp got=%b/%b/%h required=0/0/0",
                  icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (icb.icb_cmd_ready !== 1'b1 || icb.icb_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got=ready %b valid %b required=ready 1 valid 0",
                  icb.icb_cmd_ready, icb.icb_rsp_valid);
      end
      @(posedge clk);
      #1;
   endtask

   // Fill words 0..63 and read some back, one command per cycle
   task automatic test_back_to_back();
      int c0;
      int c1;
      rdy_mode = 2'd1;
      c0 = cyc;
      for (int i = 0; i < 64; i++) send(BASE + 32'(4 * i), 1'b0, $urandom, 4'hF);
      for (int i = 0; i < 16; i++) send(BASE + 32'(4 * $urandom_range(0, 63)), 1'b1, 32'h0, 4'h0);
      c1 = cyc;
      checks++;
      if (c1 - c0 !== 80) begin
         failures++;
         $display("FAIL back_to_back_cycles got=%0d required=80", c1 - c0);
      end
      drain();
   endtask

   task automatic test_directed();
      send(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
      send(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      checks++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_err !== 1'b0 || icb.icb_rsp_rdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL read_latency got=%b/%b/%h required=1/0/deadbeef",
                  icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_wmask();
      send(BASE + 32'h20, 1'b0, 32'hFFFF_FFFF, 4'hF);
      send(BASE + 32'h20, 1'b0, 32'h1122_3344, 4'b0101);
      send(BASE + 32'h20, 1'b0, 32'h0BAD_0BAD, 4'b0000);
      send(BASE + 32'h20, 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      checks++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_rdata !== 32'hFF22_FF44) begin
         failures++;
         $display("FAIL wmask_merge got=%b/%h required=1/ff22ff44", icb.icb_rsp_valid, icb.icb_rsp_rdata);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_out_of_range();
      send(32'h1FFF_FFFC, 1'b1, 32'h0, 4'h0);
      send(32'h2001_0000, 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      checks++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_err !== 1'b1 || icb.icb_rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL out_of_range_rsp got=%b/%b/%h required=1/1/0",
                  icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata);
      end
      @(posedge clk);
      #1;
      send(32'h2001_0000, 1'b0, 32'h1234_5678, 4'hF);
      drain();
   endtask

   task automatic test_misalign();
      logic [W-1:0] want;
`ifdef ICB_SLV_MISALIGN_ERR_EN
      want = {1'b1, 32'h0};
`else
      want = {1'b0, 32'hCAFE_F00D};
`endif
      send(BASE, 1'b0, 32'hCAFE_F00D, 4'hF);
      send(BASE + 32'h2, 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      checks++;
      if (icb.icb_rsp_valid !== 1'b1 || {icb.icb_rsp_err, icb.icb_rsp_rdata} !== want) begin
         failures++;
         $display("FAIL misalign_rsp got=%b/%h required=1/%h",
                  icb.icb_rsp_valid, {icb.icb_rsp_err, icb.icb_rsp_rdata}, want);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_backpressure();
      int bad;
      rdy_mode = 2'd0;
      send(BASE + 32'h0, 1'b1, 32'h0, 4'h0);
      send(BASE + 32'h4, 1'b1, 32'h0, 4'h0);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_addr  = BASE + 32'h8;
      icb.icb_cmd_read  = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (icb.icb_cmd_ready !== 1'b0 || sram_cs !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_blocks_cmd got=%0d bad cycles required=0", bad);
      end
      checks++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_rdata !== ref_mem[0]) begin
         failures++;
         $display("FAIL full_head got=%b/%h required=1/%h", icb.icb_rsp_valid, icb.icb_rsp_rdata, ref_mem[0]);
      end
      @(posedge clk);
      #1;
      rdy_mode = 2'd1;
      send(BASE + 32'h8, 1'b1, 32'h0, 4'h0);
      drain();
   endtask

   task automatic test_random();
      logic [31:0] a;
      int          sel;
      int          gap;
      rdy_mode = 2'd2;
      for (int i = 0; i < 120; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 8));
         else if (sel == 1) a = BASE + SIZE + 32'(4 * $urandom_range(0, 8));
         else if (sel == 2) a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
         else               a = BASE + 32'(4 * $urandom_range(0, 63));
         send(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int bad;
      rdy_mode = 2'd0;
      send(BASE + 32'h0, 1'b1, 32'h0, 4'h0);
      send(BASE + 32'h4, 1'b1, 32'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (icb.icb_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_valid got=%b required=0", icb.icb_rsp_valid);
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rdy_mode = 2'd1;
      @(negedge clk);
      checks++;
      if (icb.icb_cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_ready got=%b required=1", icb.icb_cmd_ready);
      end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (icb.icb_rsp_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_mid_stale got=%0d valid cycles required=0", bad);
      end
      @(posedge clk);
      #1;
      send(BASE + 32'h10, 1'b1, 32'h0, 4'h0);
      drain();
   endtask

   initial begin
      rst_n             = 1'b0;
      rdy_mode          = 2'd1;
      icb.icb_cmd_valid = 1'b0;
      icb.icb_cmd_addr  = 32'h0;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_wdata = 32'h0;
      icb.icb_cmd_wmask = 4'h0;
      fork
         monitor();
      join_none
      test_reset();
      test_back_to_back();
      test_directed();
      test_wmask();
      test_out_of_range();
      test_misalign();
      test_backpressure();
      test_random();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected got=%0d entries required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=still running required=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
